mem_arbiter: RTL and testbench

//  Shares one unified memory bus between the instruction-fetch requester (stage_if) and the

---
 rtl/mem_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Purpose : arbitrate one unified memory bus between the ifetch and data requesters.
// Latency : request to bus_valid is 1 cycle; done is combinational with bus_rsp_valid.
// Backpres: bus outputs are held stable until bus_ready; requesters stall until done.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   i_req/i_addr -> i_done/i_data    ifetch read port, i_stallreq = i_req & ~i_done
//   d_req/d_we/d_addr/d_w_data/d_w_mask -> d_done/d_r_data    data port, d_stallreq
//   bus_valid/bus_ready/bus_addr/bus_we/bus_w_data/bus_w_mask  unified bus request
//   bus_rsp_valid/bus_rsp_data       unified bus response
//   stat_i_grants/stat_d_grants/stat_conflicts   perf counters
// Optional feature: define RVCPU_MEM_ARB_STATS_EN to build the perf counters;
// otherwise the stat ports are tied to zero and no counter flops exist.
module mem_arbiter #(
  parameter int Width     = 32,
  parameter int MaxStarve = 4
) (
  input  logic             clk,
  input  logic             rst,
  // ifetch requester
  input  logic             i_req,
  input  logic [Width-1:0] i_addr,
  output logic             i_done,
  output logic [Width-1:0] i_data,
  output logic             i_stallreq,
  // data requester
  input  logic             d_req,
  input  logic             d_we,
  input  logic [Width-1:0] d_addr,
  input  logic [Width-1:0] d_w_data,
  input  logic [3:0]       d_w_mask,
  output logic             d_done,
  output logic [Width-1:0] d_r_data,
  output logic             d_stallreq,
  // unified bus
  output logic             bus_valid,
  input  logic             bus_ready,
  output logic [Width-1:0] bus_addr,
  output logic             bus_we,
  output logic [Width-1:0] bus_w_data,
  output logic [3:0]       bus_w_mask,
  input  logic             bus_rsp_valid,
  input  logic [Width-1:0] bus_rsp_data,
  // perf counters
  output logic [31:0]      stat_i_grants,
  output logic [31:0]      stat_d_grants,
  output logic [31:0]      stat_conflicts
);

  localparam int StarveW = $clog2(MaxStarve + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(MaxStarve);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e             r_state;
  state_e             w_state_nxt;
  logic               r_owner_d;     // 1: data requester owns the transaction
  logic [StarveW-1:0] r_starve;      // consecutive data grants while ifetch waited
  logic [Width-1:0]   r_bus_addr;
  logic               r_bus_we;
  logic [Width-1:0]   r_bus_w_data;
  logic [3:0]         r_bus_w_mask;

  logic               w_grant_i;
  logic               w_grant_d;
  logic               w_i_done;
  logic               w_d_done;

  // Next-state and grant decode. Requests are only looked at in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_i   = 1'b0;
    w_grant_d   = 1'b0;
    w_i_done    = 1'b0;
    w_d_done    = 1'b0;
    unique case (r_state)
      IDLE: begin
        // Data wins a conflict unless ifetch has already been passed over MaxStarve times.
        if (i_req && (!d_req || (r_starve == StarveMax))) begin
          w_grant_i = 1'b1;
        end else if (d_req) begin
          w_grant_d = 1'b1;
        end
        if (w_grant_i || w_grant_d) begin
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        if (bus_ready) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (bus_rsp_valid) begin
          w_state_nxt = IDLE;
          w_i_done    = !r_owner_d;
          w_d_done    = r_owner_d;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_owner_d    <= 1'b0;
      r_starve     <= '0;
      r_bus_addr   <= '0;
      r_bus_we     <= 1'b0;
      r_bus_w_data <= '0;
      r_bus_w_mask <= 4'b0000;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_i) begin
        r_owner_d    <= 1'b0;
        r_bus_addr   <= i_addr;
        r_bus_we     <= 1'b0;
        r_bus_w_data <= '0;
        r_bus_w_mask <= 4'b0000;
        r_starve     <= '0;
      end else if (w_grant_d) begin
        r_owner_d    <= 1'b1;
        r_bus_addr   <= d_addr;
        r_bus_we     <= d_we;
        r_bus_w_data <= d_we ? d_w_data : '0;
        r_bus_w_mask <= d_we ? d_w_mask : 4'b0000;
        if (i_req && (r_starve != StarveMax)) begin
          r_starve <= r_starve + 1'b1;
        end
      end
    end
  end

  assign bus_valid  = (r_state == REQ);
  assign bus_addr   = r_bus_addr;
  assign bus_we     = r_bus_we;
  assign bus_w_data = r_bus_w_data;
  assign bus_w_mask = r_bus_w_mask;

  assign i_done     = w_i_done;
  assign i_data     = w_i_done ? bus_rsp_data : '0;
  assign d_done     = w_d_done;
  // Write acks carry no data; force zero so the pipeline never sees bus garbage.
  assign d_r_data   = (w_d_done && !r_bus_we) ? bus_rsp_data : '0;

  assign i_stallreq = i_req && !w_i_done;
  assign d_stallreq = d_req && !w_d_done;

`ifdef RVCPU_MEM_ARB_STATS_EN
  logic [31:0] r_stat_i;
  logic [31:0] r_stat_d;
  logic [31:0] r_stat_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_i <= '0;
      r_stat_d <= '0;
      r_stat_c <= '0;
    end else begin
      if (w_grant_i) r_stat_i <= r_stat_i + 32'd1;
      if (w_grant_d) r_stat_d <= r_stat_d + 32'd1;
      if ((r_state == IDLE) && i_req && d_req) r_stat_c <= r_stat_c + 32'd1;
    end
  end

  assign stat_i_grants  = r_stat_i;
  assign stat_d_grants  = r_stat_d;
  assign stat_conflicts = r_stat_c;
`else
  assign stat_i_grants  = '0;
  assign stat_d_grants  = '0;
  assign stat_conflicts = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a small bus responder plus requester tasks,
// with expected values written out by hand for each scenario.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_done;
  logic [31:0] i_data;
  logic        i_stallreq;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_w_data;
  logic [3:0]  d_w_mask;
  logic        d_done;
  logic [31:0] d_r_data;
  logic        d_stallreq;
  logic        bus_valid;
  logic        bus_ready;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [31:0] bus_w_data;
  logic [3:0]  bus_w_mask;
  logic        bus_rsp_valid;
  logic [31:0] bus_rsp_data;
  logic [31:0] stat_i_grants;
  logic [31:0] stat_d_grants;
  logic [31:0] stat_conflicts;

  int n_checks = 0;
  int n_errors = 0;

  // responder control
  int          ready_wait = 0;
  int          wait_cnt   = 0;
  bit          manual     = 1'b0;
  logic [31:0] acc_q[$];
  bit          done_q[$];     // completion order, 1 = data
  logic [31:0] rd_i, rd_d;

  always #5 clk = ~clk;

  mem_arbiter #(.Width(32), .MaxStarve(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_data(i_data), .i_stallreq(i_stallreq),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_w_data(d_w_data), .d_w_mask(d_w_mask),
    .d_done(d_done), .d_r_data(d_r_data), .d_stallreq(d_stallreq),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr), .bus_we(bus_we),
    .bus_w_data(bus_w_data), .bus_w_mask(bus_w_mask),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_data(bus_rsp_data),
    .stat_i_grants(stat_i_grants), .stat_d_grants(stat_d_grants), .stat_conflicts(stat_conflicts)
  );

  assign bus_ready = bus_valid && (wait_cnt >= ready_wait);

  function automatic logic [31:0] rsp_of(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0000_0013 : ~a;
  endfunction

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Bus model: accept when ready, answer the cycle after acceptance.
  bit          r_acc;
  logic [31:0] r_acc_addr;
  int          r_wait_nxt;
  initial begin
    bus_rsp_valid = 1'b0;
    bus_rsp_data  = '0;
    forever begin
      @(negedge clk);
      r_acc      = bus_valid && bus_ready;
      r_acc_addr = bus_addr;
      if (r_acc) acc_q.push_back(bus_addr);
      r_wait_nxt = (bus_valid && !r_acc) ? wait_cnt + 1 : 0;
      @(posedge clk);
      #1;
      wait_cnt = r_wait_nxt;
      if (!manual) begin
        bus_rsp_valid = r_acc;
        bus_rsp_data  = r_acc ? rsp_of(r_acc_addr) : 32'h0;
      end
    end
  end

  // Requester tasks: called one delta after a rising edge.
  task automatic ifetch_txn(input logic [31:0] a, output logic [31:0] data);
    bit got = 1'b0;
    i_req  = 1'b1;
    i_addr = a;
    data   = '0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (i_done) begin
        got  = 1'b1;
        data = i_data;
        done_q.push_back(1'b0);
        break;
      end
    end
    if (!got) check("i_timeout", 0, 1);
    @(posedge clk);
    #1;
    i_req = 1'b0;
  endtask

  task automatic data_txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] m, output logic [31:0] data);
    bit got = 1'b0;
    d_req    = 1'b1;
    d_we     = we;
    d_addr   = a;
    d_w_data = wd;
    d_w_mask = m;
    data     = '0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (d_done) begin
        got  = 1'b1;
        data = d_r_data;
        done_q.push_back(1'b1);
        break;
      end
    end
    if (!got) check("d_timeout", 0, 1);
    @(posedge clk);
    #1;
    d_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_addr[6];
    rst = 1'b1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_w_data = 0; d_w_mask = 0;

    // reset state
    do_reset();
    @(negedge clk);
    check("rst_bus_valid", bus_valid, 0);
    check("rst_bus_we", bus_we, 0);
    check("rst_bus_fields", {bus_addr, bus_w_data, bus_w_mask}, 68'h0);
    check("rst_done", {i_done, d_done, i_stallreq, d_stallreq}, 4'b0000);
    check("rst_stats", {stat_i_grants, stat_d_grants, stat_conflicts}, 96'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: ifetch only, minimum latency
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 32'h100;
    @(negedge clk);
    check("t1_c0_valid", bus_valid, 0);
    check("t1_c0_stall", i_stallreq, 1);
    @(negedge clk);
    check("t1_c1_bus", {bus_valid, bus_we, bus_addr, bus_w_mask}, {1'b1, 1'b0, 32'h100, 4'b0000});
    @(negedge clk);
    check("t1_c2_valid", bus_valid, 0);
    check("t1_c2_done", {i_done, d_done, i_stallreq}, 3'b100);
    check("t1_c2_data", i_data, 32'h13);
    @(posedge clk); #1;
    i_req = 1'b0;
    @(negedge clk);
    check("t1_c3_done", i_done, 0);

    // 2: simultaneous requests, data goes first
    @(posedge clk); #1;
    acc_q.delete(); done_q.delete();
    fork
      ifetch_txn(32'h100, rd_i);
      data_txn(1'b0, 32'h2000, 32'h0, 4'h0, rd_d);
    join
    check("t2_first_grant", acc_q[0], 32'h2000);
    check("t2_second_grant", acc_q[1], 32'h100);
    check("t2_done_order", {done_q[0], done_q[1]}, 2'b10);
    check("t2_d_data", rd_d, 32'hFFFF_DFFF);
    check("t2_i_data", rd_i, 32'h13);

    // 3: continuous data with ifetch waiting, ifetch gets the 5th grant
    acc_q.delete(); done_q.delete();
    fork
      begin
        for (int k = 0; k < 5; k++) data_txn(1'b0, 32'h2000 + 32'(4 * k), 32'h0, 4'h0, rd_d);
      end
      ifetch_txn(32'h100, rd_i);
    join
    exp_addr = '{32'h2000, 32'h2004, 32'h2008, 32'h200C, 32'h100, 32'h2010};
    check("t3_n_grants", acc_q.size(), 6);
    for (int k = 0; k < 6; k++) check($sformatf("t3_grant%0d", k), acc_q[k], exp_addr[k]);
    check("t3_i_data", rd_i, 32'h13);

    // 4: write held off by bus_ready for 3 cycles
    @(posedge clk); #1;
    ready_wait = 3;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h3000; d_w_data = 32'hDEAD_BEEF; d_w_mask = 4'b0011;
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("t4_hold_c%0d", k), {bus_valid, bus_we, bus_addr, bus_w_data, bus_w_mask},
            {1'b1, 1'b1, 32'h3000, 32'hDEAD_BEEF, 4'b0011});
      check($sformatf("t4_ready_c%0d", k), bus_ready, (k == 4));
    end
    @(negedge clk);
    check("t4_done", {d_done, i_done, bus_valid}, 3'b100);
    check("t4_wr_rdata", d_r_data, 32'h0);
    @(posedge clk); #1;
    d_req = 1'b0; d_we = 1'b0; ready_wait = 0;

    // 5: reset while waiting for the response, late response ignored
    @(posedge clk); #1;
    manual = 1'b1;
    i_req = 1'b1; i_addr = 32'h100;
    @(negedge clk);
    @(negedge clk);
    check("t5_c1_valid", bus_valid, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("t5_c2_no_done", i_done, 0);
    @(posedge clk); #1;
    rst = 1'b0; i_req = 1'b0;
    bus_rsp_valid = 1'b1; bus_rsp_data = 32'h13;
    @(negedge clk);
    check("t5_c3_bus", {bus_valid, bus_addr}, 33'h0);
    check("t5_c3_late_rsp", {i_done, d_done}, 2'b00);
    @(posedge clk); #1;
    bus_rsp_valid = 1'b0; bus_rsp_data = 32'h0;
    manual = 1'b0;
    @(negedge clk);
    check("t5_c4_idle", {i_done, d_done, bus_valid}, 3'b000);

    // 6: counters after 3 I grants, 2 D grants, 2 conflict cycles
    @(posedge clk); #1;
    fork
      ifetch_txn(32'h100, rd_i);
      data_txn(1'b0, 32'h2000, 32'h0, 4'h0, rd_d);
    join
    fork
      ifetch_txn(32'h100, rd_i);
      data_txn(1'b0, 32'h2004, 32'h0, 4'h0, rd_d);
    join
    ifetch_txn(32'h104, rd_i);
    check("t6_third_i_data", rd_i, 32'hFFFF_FEFB);
    @(negedge clk);
`ifdef RVCPU_MEM_ARB_STATS_EN
    check("t6_stats", {stat_i_grants, stat_d_grants, stat_conflicts}, {32'd3, 32'd2, 32'd2});
`else
    check("t6_stats", {stat_i_grants, stat_d_grants, stat_conflicts}, 96'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
